line_fill_responder: RTL

Backing-memory responder serving the data cache's miss traffic on the memory stage. It accepts one line request at a time, read (refill) or write (writeback), models fixed access latency with a countdown, then moves the line as a burst of 32-bit beats. Memory data is held in an internal word array. It sits between the cache controller's miss/stall logic and the system. The cache is the initiator; this block is the responder.

---
 rtl/line_fill_responder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/line_fill_responder.sv
// Backing-memory responder for data-cache line refills and writebacks.
// One request at a time: fixed access latency, then a burst of 32-bit beats.
module line_fill_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 16384,
    parameter int BLOCK_WORDS = 4,
    parameter int LATENCY     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  wr_valid,
    input  logic [31:0]           wr_data,
    output logic                  wr_ready,
    output logic                  rd_valid,
    output logic [31:0]           rd_data,
    output logic                  rd_last,
    output logic                  done,
    output logic                  busy
);

    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int BEAT_W = $clog2(BLOCK_WORDS);
    localparam int LINE_W = IDX_W - BEAT_W;
    localparam int CNT_W  = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RBURST,
        S_WBURST,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                write_q, write_d;
    logic [LINE_W-1:0]   line_q,  line_d;
    logic [BEAT_W-1:0]   beat_q,  beat_d;
    logic [CNT_W-1:0]    wait_q,  wait_d;

    logic [31:0]         mem [DEPTH_WORDS];
    logic                mem_we;
    logic [IDX_W-1:0]    mem_idx;
    logic                last_beat;
    logic                addr_unused;

    // Only the line-index bits of the address matter; everything else aliases.
    assign addr_unused = ^req_addr;

    assign mem_idx   = {line_q, beat_q};
    assign last_beat = (beat_q == BEAT_W'(BLOCK_WORDS - 1));

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        line_d  = line_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        mem_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    line_d  = req_addr[BEAT_W+2 +: LINE_W];
                    beat_d  = '0;
                    wait_d  = CNT_W'(LATENCY);
                    if (LATENCY == 0) begin
                        state_d = req_write ? S_WBURST : S_RBURST;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                wait_d = wait_q - 1'b1;
                if (wait_q == CNT_W'(1)) begin
                    state_d = write_q ? S_WBURST : S_RBURST;
                end
            end
            S_RBURST: begin
                if (last_beat) begin
                    state_d = S_DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            S_WBURST: begin
                if (wr_valid) begin
                    mem_we = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            line_q  <= '0;
            beat_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            line_q  <= line_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
        end
    end

    // The array is deliberately outside reset so an aborted burst keeps committed beats.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= wr_data;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign wr_ready  = (state_q == S_WBURST);
    assign rd_valid  = (state_q == S_RBURST);
    assign rd_last   = rd_valid && last_beat;
    assign rd_data   = rd_valid ? mem[mem_idx] : 32'h0;

endmodule
